// File: rtl/aq_axi_lite_local_master_pkg.sv
// Shared types and constants for the AXI4-Lite to AQ_LOCAL master bridge.
package aq_axi_lite_local_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/aq_axi_lite_hold_reg.sv
// One-entry valid/ready holding register: takes a beat while empty and
// keeps it until the bridge consumes it.
module aq_axi_lite_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             consume_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Consume only happens while full, and accept only while empty, so the two never collide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (consume_i) begin
            full_d = 1'b0;
        end
        if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/aq_axi_lite_local_master.sv
// Replays single-beat AXI4-Lite reads/writes as AQ_LOCAL master cycles,
// with a per-access ACK timeout and a sticky timeout flag.
module aq_axi_lite_local_master
    import aq_axi_lite_local_master_pkg::*;
#(
    parameter int          TIMEOUT   = DEFAULT_TIMEOUT,
    parameter logic [31:0] ADDR_MASK = 32'h0000_00FF
) (
    input  logic        AQ_LOCAL_CLK,
    input  logic        RST_N,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic        AQ_LOCAL_CS,
    output logic        AQ_LOCAL_RNW,
    output logic [31:0] AQ_LOCAL_ADDR,
    output logic [3:0]  AQ_LOCAL_BE,
    output logic [31:0] AQ_LOCAL_WDATA,
    input  logic        AQ_LOCAL_ACK,
    input  logic [31:0] AQ_LOCAL_RDATA,
    output logic        TIMEOUT_ERR
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic        aw_full, w_full, ar_full;
    logic [31:0] aw_addr, ar_addr;
    logic [35:0] w_beat;
    logic        grant_wr, grant_rd;

    state_t      state_q, state_d;
    logic        last_rd_q, last_rd_d;
    logic        rnw_q, rnw_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic        terr_q, terr_d;

    aq_axi_lite_hold_reg #(.WIDTH(32)) u_aw_hold (
        .clk_i     (AQ_LOCAL_CLK),
        .rst_n_i   (RST_N),
        .valid_i   (S_AXI_AWVALID),
        .ready_o   (S_AXI_AWREADY),
        .data_i    (S_AXI_AWADDR),
        .consume_i (grant_wr),
        .full_o    (aw_full),
        .data_o    (aw_addr)
    );

    aq_axi_lite_hold_reg #(.WIDTH(36)) u_w_hold (
        .clk_i     (AQ_LOCAL_CLK),
        .rst_n_i   (RST_N),
        .valid_i   (S_AXI_WVALID),
        .ready_o   (S_AXI_WREADY),
        .data_i    ({S_AXI_WSTRB, S_AXI_WDATA}),
        .consume_i (grant_wr),
        .full_o    (w_full),
        .data_o    (w_beat)
    );

    aq_axi_lite_hold_reg #(.WIDTH(32)) u_ar_hold (
        .clk_i     (AQ_LOCAL_CLK),
        .rst_n_i   (RST_N),
        .valid_i   (S_AXI_ARVALID),
        .ready_o   (S_AXI_ARREADY),
        .data_i    (S_AXI_ARADDR),
        .consume_i (grant_rd),
        .full_o    (ar_full),
        .data_o    (ar_addr)
    );

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        rnw_d     = rnw_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        terr_d    = terr_q;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // On a tie, the type not granted last wins.
                grant_rd = ar_full && (!(aw_full && w_full) || !last_rd_q);
                grant_wr = aw_full && w_full && !grant_rd;
                if (grant_rd) begin
                    state_d   = ST_ACCESS;
                    last_rd_d = 1'b1;
                    rnw_d     = 1'b1;
                    addr_d    = ar_addr & ADDR_MASK;
                    be_d      = 4'hF;
                    cnt_d     = '0;
                end else if (grant_wr) begin
                    state_d   = ST_ACCESS;
                    last_rd_d = 1'b0;
                    rnw_d     = 1'b0;
                    addr_d    = aw_addr & ADDR_MASK;
                    be_d      = w_beat[35:32];
                    wdata_d   = w_beat[31:0];
                    cnt_d     = '0;
                end
            end
            ST_ACCESS: begin
                if (AQ_LOCAL_ACK) begin
                    if (rnw_q) begin
                        rdata_d = AQ_LOCAL_RDATA;
                    end
                    resp_d  = RESP_OKAY;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_d  = RESP_SLVERR;
                    rdata_d = '0;
                    terr_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if ((rnw_q && S_AXI_RREADY) || (!rnw_q && S_AXI_BREADY)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AQ_LOCAL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            last_rd_q <= 1'b1;
            rnw_q     <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            rnw_q     <= rnw_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            terr_q    <= terr_d;
        end
    end

    // CS follows the state register so an async reset drops it at once.
    assign AQ_LOCAL_CS    = (state_q == ST_ACCESS);
    assign AQ_LOCAL_RNW   = rnw_q;
    assign AQ_LOCAL_ADDR  = addr_q;
    assign AQ_LOCAL_BE    = be_q;
    assign AQ_LOCAL_WDATA = wdata_q;

    assign S_AXI_BVALID = (state_q == ST_RESP) && !rnw_q;
    assign S_AXI_RVALID = (state_q == ST_RESP) && rnw_q;
    assign S_AXI_BRESP  = resp_q;
    assign S_AXI_RRESP  = resp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign TIMEOUT_ERR  = terr_q;

endmodule
